issue_scoreboard: RTL and testbench
===================================

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter LAT_W, default 3, latency field width.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  in  1  pipeline flush, kill all pending entries.
REQ-005 SHALL have ports master_valid / slave_valid  in  1  issue slot holds an instruction.
REQ-006 SHALL have ports master_rs, master_rt, slave_rs, slave_rt  in  5  source register addresses.
REQ-007 SHALL have ports master_dst_en / slave_dst_en  in  1  instruction writes a GPR.
REQ-008 SHALL have ports master_dst / slave_dst  in  5  destination register.
REQ-009 SHALL have ports master_lat / slave_lat  in  LAT_W  cycles until result is forwardable; all-ones = sticky.
REQ-010 SHALL have ports master_wb_en / slave_wb_en  in  1, master_wb_addr / slave_wb_addr  in  5  writeback release.
REQ-011 SHALL have ports master_issue_ok / slave_issue_ok  out  1  slot may issue this cycle.
REQ-012 SHALL have port perf_stall_cycles  out  32  stall counter (macro-gated, REQ-027).

Function
REQ-013 SHALL keep one LAT_W-bit countdown cnt[r] per register r=1..31; r0 always ready, never written.
REQ-014 SHALL treat register r ready iff cnt[r]==0; source address 0 always ready.
REQ-015 SHALL assert master_issue_ok combinationally iff master_valid and master_rs, master_rt ready.
REQ-016 SHALL assert slave_issue_ok iff slave_valid, master_issue_ok, slave sources ready, and no slave source equals master_dst with master_dst_en and master_dst!=0.
REQ-017 SHALL count an issue (fire) only when valid and issue_ok are both high in the same cycle.
REQ-018 SHALL on fire with dst_en and dst!=0 load cnt[dst]=lat at the next edge; lat=0 leaves register ready.
REQ-019 SHALL decrement each non-zero, non-sticky cnt by 1 per cycle, saturating at 0.
REQ-020 SHALL hold sticky entries (all-ones) until a wb_en with matching wb_addr clears them to 0.
REQ-021 SHALL clear any entry named by wb_en/wb_addr, sticky or not.
REQ-022 SHALL, on the same register in one cycle, give priority slave fire > master fire > writeback clear > decrement.
REQ-023 SHALL on flush zero all counters at the next edge, flush overriding fires in that cycle.
REQ-024 SHALL drive issue_ok outputs from current state only; no cycle of latency from cnt to ok.

Reset
REQ-025 SHALL on rst_n low asynchronously zero all cnt and perf_stall_cycles; both issue_ok then follow REQ-015/016 (ready state).
REQ-026 SHALL discard any in-flight sticky entry on reset mid-operation.

Configuration
REQ-027 SHALL, with SCOREBOARD_PERF_EN defined, increment perf_stall_cycles (wrapping at 2^32) each cycle master_valid is high and master_issue_ok low; without it the port SHALL be tied to 0 and no counter flops exist.

Structure
REQ-028 SHALL place lat_t, reg_addr_t and constant SB_STICKY (all-ones) in shared package scoreboard_pkg.
REQ-029 SHALL instantiate sub-module sb_entry (one counter, set/clear/decrement/flush logic) 31 times.

Verification
REQ-030 Master fires dst=5 lat=2; next cycle master_rs=5 -> master_issue_ok=0; two cycles after fire -> 1.
REQ-031 Master dst=8 dst_en, slave_rs=8, both valid, no pending -> master_issue_ok=1, slave_issue_ok=0.
REQ-032 Master fires dst=3 lat=7 (sticky); wait 20 cycles -> r3 not ready; master_wb_en, wb_addr=3 -> ready next cycle.
REQ-033 Master and slave both fire dst=9, master lat=1, slave lat=4 -> r9 ready exactly 4 cycles later.
REQ-034 Pending r4 lat=5 and r6 sticky, assert flush one cycle -> both ready next cycle; reset mid-op same result.
REQ-035 With SCOREBOARD_PERF_EN, master stalled 3 cycles on r5 -> perf_stall_cycles=3; without macro stays 0.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the dual-issue GPR scoreboard.
package scoreboard_pkg;

  localparam int SB_LAT_W = 3;

  typedef logic [SB_LAT_W-1:0] lat_t;
  typedef logic [4:0]          reg_addr_t;

  localparam lat_t SB_STICKY = '1;

endpackage

// File: rtl/sb_entry.sv
// One register's latency countdown; all-ones holds until a writeback.
module sb_entry
  import scoreboard_pkg::*;
#(
  parameter int LAT_W = SB_LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             set_s,
  input  logic [LAT_W-1:0] lat_s,
  input  logic             set_m,
  input  logic [LAT_W-1:0] lat_m,
  input  logic             clr,
  output logic             ready
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (set_s) begin
      cnt_d = lat_s;
    end else if (set_m) begin
      cnt_d = lat_m;
    end else if (clr) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ready = (cnt_q == '0);

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-issue RAW scoreboard over 31 GPRs; master slot gates slave slot.
// Stall counter is built only with SCOREBOARD_PERF_EN defined.
module issue_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             master_valid,
  input  logic             slave_valid,
  input  reg_addr_t        master_rs,
  input  reg_addr_t        master_rt,
  input  reg_addr_t        slave_rs,
  input  reg_addr_t        slave_rt,
  input  logic             master_dst_en,
  input  logic             slave_dst_en,
  input  reg_addr_t        master_dst,
  input  reg_addr_t        slave_dst,
  input  logic [LAT_W-1:0] master_lat,
  input  logic [LAT_W-1:0] slave_lat,
  input  logic             master_wb_en,
  input  logic             slave_wb_en,
  input  reg_addr_t        master_wb_addr,
  input  reg_addr_t        slave_wb_addr,
  output logic             master_issue_ok,
  output logic             slave_issue_ok,
  output logic [31:0]      perf_stall_cycles
);

  logic [31:0] rdy;
  logic        m_ok;
  logic        s_ok;
  logic        hazard;
  logic        m_wr;
  logic        s_wr;

  assign rdy[0] = 1'b1;

  for (genvar r = 1; r < 32; r++) begin : g_ent
    sb_entry #(.LAT_W(LAT_W)) u_ent (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .set_s (s_wr && slave_dst == reg_addr_t'(r)),
      .lat_s (slave_lat),
      .set_m (m_wr && master_dst == reg_addr_t'(r)),
      .lat_m (master_lat),
      .clr   ((master_wb_en && master_wb_addr == reg_addr_t'(r)) ||
              (slave_wb_en && slave_wb_addr == reg_addr_t'(r))),
      .ready (rdy[r])
    );
  end

  // Slave may not read what its paired master writes this cycle.
  always_comb begin
    m_ok   = master_valid && rdy[master_rs] && rdy[master_rt];
    hazard = master_dst_en && (master_dst != '0) &&
             (slave_rs == master_dst || slave_rt == master_dst);
    s_ok   = slave_valid && m_ok && rdy[slave_rs] &&
             rdy[slave_rt] && !hazard;
    m_wr   = m_ok && master_dst_en && (master_dst != '0);
    s_wr   = s_ok && slave_dst_en && (slave_dst != '0);
  end

  assign master_issue_ok = m_ok;
  assign slave_issue_ok  = s_ok;

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] perf_q;
  logic [31:0] perf_d;

  always_comb begin
    perf_d = perf_q;
    if (master_valid && !m_ok) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard-queue bench for issue_scoreboard with a per-register model.
module tb_issue_scoreboard;
  import scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        mv, sv;
  reg_addr_t   mrs, mrt, srs, srt, md, sd, mwa, swa;
  logic        mde, sde, mwb, swb;
  lat_t        mlat, slat;
  logic        mok, sok;
  logic [31:0] perf;

  int vectors = 0;
  int errors  = 0;

  lat_t        m_cnt [32];
  logic [31:0] m_perf;

  typedef struct {
    logic        mok;
    logic        sok;
    logic [31:0] perf;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  issue_scoreboard #(.LAT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .master_valid(mv), .slave_valid(sv),
    .master_rs(mrs), .master_rt(mrt),
    .slave_rs(srs), .slave_rt(srt),
    .master_dst_en(mde), .slave_dst_en(sde),
    .master_dst(md), .slave_dst(sd),
    .master_lat(mlat), .slave_lat(slat),
    .master_wb_en(mwb), .slave_wb_en(swb),
    .master_wb_addr(mwa), .slave_wb_addr(swa),
    .master_issue_ok(mok), .slave_issue_ok(sok),
    .perf_stall_cycles(perf)
  );

  function automatic logic rdy(input reg_addr_t a);
    return (a == 5'd0) || (m_cnt[a] == '0);
  endfunction

  task automatic idle();
    flush = 0; mv = 0; sv = 0;
    mrs = 0; mrt = 0; srs = 0; srt = 0;
    mde = 0; sde = 0; md = 0; sd = 0;
    mlat = 0; slat = 0;
    mwb = 0; swb = 0; mwa = 0; swa = 0;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) m_cnt[r] = '0;
    m_perf = '0;
  endtask

  // Called just after a negedge with inputs set; ends at the next negedge.
  task automatic cycle(input string nm);
    exp_t e, g;
    logic hz;
    lat_t nx [32];
    #1;
    e.mok = mv && rdy(mrs) && rdy(mrt);
    hz = mde && (md != 0) && (srs == md || srt == md);
    e.sok = sv && e.mok && rdy(srs) && rdy(srt) && !hz;
`ifdef SCOREBOARD_PERF_EN
    e.perf = m_perf;
`else
    e.perf = 32'd0;
`endif
    exp_q.push_back(e);
    #1;
    g = exp_q.pop_front();
    vectors++;
    if (mok !== g.mok || sok !== g.sok || perf !== g.perf) begin
      errors++;
      $display("FAIL %s: got m=%b s=%b perf=%0d want m=%b s=%b perf=%0d",
               nm, mok, sok, perf, g.mok, g.sok, g.perf);
    end
    for (int r = 0; r < 32; r++) begin
      nx[r] = m_cnt[r];
      if (r == 0) nx[r] = '0;
      else if (flush) nx[r] = '0;
      else if (e.sok && sde && sd == r) nx[r] = slat;
      else if (e.mok && mde && md == r) nx[r] = mlat;
      else if ((mwb && mwa == r) || (swb && swa == r)) nx[r] = '0;
      else if (m_cnt[r] == SB_STICKY) nx[r] = m_cnt[r];
      else if (m_cnt[r] != '0) nx[r] = m_cnt[r] - 1'b1;
    end
    if (mv && !e.mok) m_perf = m_perf + 32'd1;
    @(posedge clk);
    for (int r = 0; r < 32; r++) m_cnt[r] = nx[r];
    @(negedge clk);
  endtask

  task automatic expect_ok(input string nm, input logic want_m);
    #1;
    vectors++;
    if (mok !== want_m) begin
      errors++;
      $display("FAIL %s: master_issue_ok=%b want %b", nm, mok, want_m);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_clear();
    #1;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_clear();
    mv = 1; mrs = 5; mrt = 6;
    #3;
    vectors++;
    if (mok !== 1'b1 || sok !== 1'b0 || perf !== 32'd0) begin
      errors++;
      $display("FAIL reset: m=%b s=%b perf=%0d want 1 0 0", mok, sok, perf);
    end
    @(negedge clk);
    rst_n = 1;
    idle();
    cycle("reset_idle");
  endtask

  task automatic test_raw();
    idle();
    mv = 1; mde = 1; md = 5; mlat = 2;
    cycle("raw_fire");
    idle(); mv = 1; mrs = 5;
    expect_ok("raw_c1", 1'b0);
    cycle("raw_c1m");
    expect_ok("raw_c2", 1'b0);
    cycle("raw_c2m");
    expect_ok("raw_c3", 1'b1);
    cycle("raw_c3m");
  endtask

  task automatic test_dual_hazard();
    idle();
    mv = 1; sv = 1; mde = 1; md = 8; mlat = 0; srs = 8;
    #1;
    vectors++;
    if (mok !== 1'b1 || sok !== 1'b0) begin
      errors++;
      $display("FAIL dual_hazard: m=%b s=%b want 1 0", mok, sok);
    end
    #1;
    cycle("dual_hazard_m");
    idle(); mv = 1; sv = 1; srs = 8;
    cycle("dual_after_lat0");
  endtask

  task automatic test_sticky();
    idle();
    mv = 1; mde = 1; md = 3; mlat = SB_STICKY;
    cycle("sticky_fire");
    idle(); mv = 1; mrs = 3;
    for (int i = 0; i < 20; i++) cycle("sticky_hold");
    expect_ok("sticky_20", 1'b0);
    mwb = 1; mwa = 3;
    cycle("sticky_wb");
    idle(); mv = 1; mrs = 3;
    expect_ok("sticky_released", 1'b1);
    cycle("sticky_released_m");
  endtask

  task automatic test_same_dst();
    idle();
    mv = 1; sv = 1; mde = 1; sde = 1;
    md = 9; sd = 9; mlat = 1; slat = 4;
    cycle("same_dst_fire");
    idle(); mv = 1; mrt = 9;
    for (int i = 1; i <= 3; i++) cycle("same_dst_wait");
    expect_ok("same_dst_c4", 1'b0);
    cycle("same_dst_c4m");
    expect_ok("same_dst_c5", 1'b1);
    cycle("same_dst_c5m");
  endtask

  task automatic test_flush();
    idle();
    mv = 1; sv = 1; mde = 1; sde = 1;
    md = 4; mlat = 5; sd = 6; slat = SB_STICKY;
    cycle("flush_fire");
    idle(); flush = 1; mv = 1; mrs = 4; sde = 1; sd = 6;
    mde = 1; md = 7; mlat = 3;
    cycle("flush_cyc");
    idle(); mv = 1; mrs = 4; mrt = 6; sv = 1; srs = 7;
    expect_ok("flush_after", 1'b1);
    cycle("flush_after_m");
    idle();
    mv = 1; sv = 1; mde = 1; sde = 1;
    md = 4; mlat = 5; sd = 6; slat = SB_STICKY;
    cycle("rst_fire");
    idle(); mv = 1; mrs = 4; mrt = 6;
    cycle("rst_pending");
    do_reset();
    expect_ok("rst_after", 1'b1);
    cycle("rst_after_m");
  endtask

  task automatic test_perf();
    idle();
    do_reset();
    mv = 1; mde = 1; md = 5; mlat = 3;
    cycle("perf_fire");
    idle(); mv = 1; mrs = 5;
    for (int i = 0; i < 3; i++) cycle("perf_stall");
    idle();
    #1;
    vectors++;
`ifdef SCOREBOARD_PERF_EN
    if (perf !== 32'd3) begin
      errors++;
      $display("FAIL perf_count: perf=%0d want 3", perf);
    end
`else
    if (perf !== 32'd0) begin
      errors++;
      $display("FAIL perf_count: perf=%0d want 0", perf);
    end
`endif
    #1;
    cycle("perf_idle");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      idle();
      mv   = $urandom_range(0, 3) != 0;
      sv   = $urandom_range(0, 1);
      mrs  = reg_addr_t'($urandom_range(0, 7));
      mrt  = reg_addr_t'($urandom_range(0, 7));
      srs  = reg_addr_t'($urandom_range(0, 7));
      srt  = reg_addr_t'($urandom_range(0, 7));
      mde  = $urandom_range(0, 1);
      sde  = $urandom_range(0, 1);
      md   = reg_addr_t'($urandom_range(0, 7));
      sd   = reg_addr_t'($urandom_range(0, 7));
      mlat = lat_t'($urandom_range(0, 7));
      slat = lat_t'($urandom_range(0, 7));
      mwb  = $urandom_range(0, 3) == 0;
      swb  = $urandom_range(0, 3) == 0;
      mwa  = reg_addr_t'($urandom_range(0, 7));
      swa  = reg_addr_t'($urandom_range(0, 7));
      flush = $urandom_range(0, 31) == 0;
      cycle("random");
    end
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_raw();
    test_dual_hazard();
    test_sticky();
    test_same_dst();
    test_flush();
    test_perf();
    test_random();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
